// File: rtl/alu_cmd_seq_if.sv
// Command and result handshake channels between an initiator and alu_cmd_seq.
// master drives commands and consumes results; slave is the sequencer side.
interface alu_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flag;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
    input  cmd_ready, res_valid, res_data, res_flag, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
    output cmd_ready, res_valid, res_data, res_flag, res_err
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Sequencer feeding an external combinational 8-bit ALU: registers a command onto
// the ALU bus, captures the result a cycle later and returns it over a handshake.
module alu_cmd_seq (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_seq_if.slave       bus,
  input  logic               clr_sticky,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_sel,
  input  logic [7:0]         alu_out,
  input  logic [3:0]         alu_flag,
  output logic [7:0]         acc,
  output logic [3:0]         sticky_flag,
  output logic [7:0]         op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic       cmd_ready_r;
  logic       res_valid_r;
  logic       res_err_r;
  logic [7:0] res_data_r;
  logic [3:0] res_flag_r;
  logic       err_p0;
  logic       accept;
  logic       capture_ok;

  // Clear takes effect before the new flags are merged in.
  function automatic logic [3:0] sticky_next(input logic [3:0] cur,
                                             input logic       clr,
                                             input logic       cap,
                                             input logic [3:0] flags);
    logic [3:0] base;
    base = clr ? 4'h0 : cur;
    return cap ? (base | flags) : base;
  endfunction

  assign accept     = cmd_ready_r & bus.cmd_valid;
  assign capture_ok = (state == EXEC) & ~err_p0;

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_flag  = res_flag_r;
  assign bus.res_err   = res_err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
      res_data_r  <= 8'h00;
      res_flag_r  <= 4'h0;
      err_p0      <= 1'b0;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_sel     <= 4'h0;
      acc         <= 8'h00;
      sticky_flag <= 4'h0;
      op_cnt      <= 8'h00;
    end else begin
      sticky_flag <= sticky_next(sticky_flag, clr_sticky, capture_ok, alu_flag);
      case (state)
        // p0: accept a command and launch it onto the ALU bus
        IDLE: begin
          if (accept) begin
            alu_a       <= bus.cmd_use_acc ? acc : bus.cmd_a;
            alu_b       <= bus.cmd_b;
            alu_sel     <= bus.cmd_op;
            err_p0      <= (bus.cmd_op > 4'hB);
            cmd_ready_r <= 1'b0;
            state       <= EXEC;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        // p1: ALU has had a full cycle to settle; capture it
        EXEC: begin
          if (err_p0) begin
            res_data_r <= 8'h00;
            res_flag_r <= 4'h0;
            res_err_r  <= 1'b1;
          end else begin
            res_data_r <= alu_out;
            res_flag_r <= alu_flag;
            res_err_r  <= 1'b0;
            acc        <= alu_out;
          end
          res_valid_r <= 1'b1;
          state       <= DONE;
        end
        // p2: hold the result until the consumer takes it
        DONE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            op_cnt      <= op_cnt + 8'd1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_r <= 1'b0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural 8-bit ALU on its bus.
module tb_alu_cmd_seq;
  logic       clk;
  logic       rst;
  logic       clr_sticky;
  logic [7:0] alu_a, alu_b, alu_out, acc, op_cnt;
  logic [3:0] alu_sel, alu_flag, sticky_flag;
  logic [7:0] seen_a;
  int         n_checks;
  int         n_fail;

  alu_cmd_seq_if bus ();

  alu_cmd_seq dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_flag   (alu_flag),
    .acc        (acc),
    .sticky_flag(sticky_flag),
    .op_cnt     (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags: bit0 zero, bit1 carry, bit2 overflow, bit3 underflow
  function automatic logic [11:0] alu_model(input logic [3:0] sel,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic [3:0]  f;
    r = 8'h00;
    f = 4'h0;
    s = 9'h000;
    p = 16'h0000;
    case (sel)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; f[1] = s[8]; end
      4'h1: begin r = a - b; f[3] = (a < b); end
      4'h2: begin p = a * b; r = p[7:0]; f[2] = |p[15:8]; end
      4'h3: begin if (b == 8'h00) begin r = 8'hFF; f[2] = 1'b1; end else r = a / b; end
      4'h4: begin if (b == 8'h00) begin r = 8'hFF; f[2] = 1'b1; end else r = a % b; end
      4'h5: r = a;
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h9: r = ~(a | b);
      4'hA: begin r = {a[6:0], 1'b0}; f[1] = a[7]; end
      4'hB: begin r = {1'b0, a[7:1]}; f[1] = a[0]; end
      default: begin r = 8'hA5; f = 4'hE; end
    endcase
    if (sel <= 4'hB) f[0] = (r == 8'h00);
    return {f, r};
  endfunction

  always_comb begin
    {alu_flag, alu_out} = alu_model(alu_sel, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after acceptance (DUT in EXEC).
  task automatic issue(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic use_acc);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      return;
    end
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = use_acc;
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    seen_a          = alu_a;
  endtask

  // Returns at the falling edge where res_valid is first seen high.
  task automatic wait_res();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.res_valid !== 1'b1 && n < 10);
    if (bus.res_valid !== 1'b1) check("res_valid_timeout", 32'(bus.res_valid), 32'd1);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    clr_sticky      = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'h0;
    bus.cmd_a       = 8'h00;
    bus.cmd_b       = 8'h00;
    bus.cmd_use_acc = 1'b0;
    bus.res_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // add with carry
    issue(4'h0, 8'd200, 8'd100, 1'b0);
    check("add_alu_a", 32'(alu_a), 32'd200);
    check("add_alu_b", 32'(alu_b), 32'd100);
    check("add_exec_res_valid", 32'(bus.res_valid), 32'd0);
    wait_res();
    check("add_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("add_data", 32'(bus.res_data), 32'd44);
    check("add_flag", 32'(bus.res_flag), 32'h2);
    check("add_acc", 32'(acc), 32'd44);
    check("add_cnt_before", 32'(op_cnt), 32'd0);
    @(negedge clk);
    check("add_cnt_after", 32'(op_cnt), 32'd1);
    check("add_res_valid_drop", 32'(bus.res_valid), 32'd0);

    // chained accumulator subtract
    issue(4'h1, 8'd0, 8'd44, 1'b1);
    check("chain_alu_a", 32'(seen_a), 32'd44);
    wait_res();
    check("chain_data", 32'(bus.res_data), 32'd0);
    check("chain_flag", 32'(bus.res_flag), 32'h1);
    check("chain_sticky", 32'(sticky_flag), 32'h3);
    @(negedge clk);

    // divide by zero, then illegal op
    issue(4'h3, 8'd11, 8'd0, 1'b0);
    wait_res();
    check("div0_data", 32'(bus.res_data), 32'hFF);
    check("div0_flag", 32'(bus.res_flag), 32'h4);
    @(negedge clk);
    issue(4'hC, 8'd1, 8'd2, 1'b0);
    wait_res();
    check("ill_err", 32'(bus.res_err), 32'd1);
    check("ill_data", 32'(bus.res_data), 32'd0);
    check("ill_flag", 32'(bus.res_flag), 32'd0);
    check("ill_acc", 32'(acc), 32'hFF);
    check("ill_sticky", 32'(sticky_flag), 32'h7);
    @(negedge clk);
    check("cnt_four", 32'(op_cnt), 32'd4);

    // backpressure
    bus.res_ready = 1'b0;
    issue(4'h6, 8'hC1, 8'h39, 1'b0);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(bus.res_data), 32'h01);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check("bp_cnt", 32'(op_cnt), 32'd4);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_cnt_after", 32'(op_cnt), 32'd5);

    // asynchronous reset while in EXEC
    issue(4'h0, 8'd9, 8'd9, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_cnt", 32'(op_cnt), 32'd0);
    check("mid_rst_acc", 32'(acc), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_sticky", 32'(sticky_flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
    issue(4'h0, 8'd3, 8'd4, 1'b0);
    wait_res();
    check("post_rst_data", 32'(bus.res_data), 32'd7);
    @(negedge clk);
    check("post_rst_cnt", 32'(op_cnt), 32'd1);

    // counter wrap
    for (int i = 0; i < 255; i++) begin
      issue(4'h7, 8'h10, 8'(i), 1'b0);
      wait_res();
      @(negedge clk);
    end
    check("wrap_cnt", 32'(op_cnt), 32'd0);

    // sticky clear coincident with a capture
    issue(4'h0, 8'd200, 8'd100, 1'b0);
    wait_res();
    @(negedge clk);
    check("sticky_pre", 32'(sticky_flag), 32'h2);
    issue(4'h7, 8'h00, 8'h00, 1'b0);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr_res_valid", 32'(bus.res_valid), 32'd1);
    check("clr_res_flag", 32'(bus.res_flag), 32'h1);
    check("clr_sticky_cap", 32'(sticky_flag), 32'h1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr_idle", 32'(sticky_flag), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
